load_store_unit: RTL

//  Memory-access stage downstream of the execute/ALU stage in risc_v_core.

---
 rtl/load_store_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage; computes the effective address, drives a req/ack
// data port with byte lanes, and aligns/extends load data for a one-cycle register writeback.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ls_valid,
  output logic        ls_ready,
  input  logic        is_load,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        ls_done,
  output logic        ls_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;
  logic ready_nxt, req_nxt, we_nxt, wb_en_nxt, done_nxt, err_nxt, ld, ld_nxt, bad;
  logic [31:0] addr_nxt, wdata_nxt, wb_data_nxt, ea, sh, ld_data, wd_st;
  logic [3:0] be_nxt, be_st;
  logic [4:0] wb_addr_nxt;
  logic [2:0] f3, f3_nxt;
  logic [1:0] off, off_nxt;
  logic [7:0] cnt, cnt_nxt;
  assign ea = base + imm;
  // funct3[0] marks halfwords, funct3[1] words; the reserved encodings are rejected first
  assign bad = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (!is_load && funct3[2]) ||
               (funct3[0] && ea[0]) || (funct3[1] && ea[1:0] != 2'b00);
  assign be_st = funct3[1] ? 4'b1111 : funct3[0] ? (ea[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ea[1:0];
  assign wd_st = funct3[1] ? store_data : funct3[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
  assign sh = mem_rdata >> {off, 3'b000};
  assign ld_data = f3[1] ? sh : f3[0] ? {{16{~f3[2] & sh[15]}}, sh[15:0]} : {{24{~f3[2] & sh[7]}}, sh[7:0]};
  always_comb begin
    state_nxt = state;
    ready_nxt = ls_ready;
    req_nxt = mem_req;
    we_nxt = mem_we;
    addr_nxt = mem_addr;
    wdata_nxt = mem_wdata;
    be_nxt = mem_be;
    wb_en_nxt = wb_en;
    wb_addr_nxt = wb_addr;
    wb_data_nxt = wb_data;
    done_nxt = ls_done;
    err_nxt = ls_err;
    ld_nxt = ld;
    f3_nxt = f3;
    off_nxt = off;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: if (ls_valid && ls_ready) begin
        ready_nxt = 1'b0;
        cnt_nxt = 8'd0;
        if (bad) begin
          state_nxt = DONE;
          done_nxt = 1'b1;
          err_nxt = 1'b1;
        end else begin
          state_nxt = ACCESS;
          req_nxt = 1'b1;
          we_nxt = !is_load;
          addr_nxt = {ea[31:2], 2'b00};
          be_nxt = be_st;
          wdata_nxt = wd_st;
          wb_addr_nxt = rd;
          ld_nxt = is_load;
          f3_nxt = funct3;
          off_nxt = ea[1:0];
        end
      end
      ACCESS: begin
        cnt_nxt = cnt + 8'd1;
        if (mem_ack) begin
          state_nxt = DONE;
          req_nxt = 1'b0;
          done_nxt = 1'b1;
          wb_en_nxt = ld && wb_addr != 5'd0;
          wb_data_nxt = ld_data;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          state_nxt = DONE;
          req_nxt = 1'b0;
          done_nxt = 1'b1;
          err_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
        done_nxt = 1'b0;
        err_nxt = 1'b0;
        wb_en_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ls_ready <= 1'b1;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
      wb_en <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      ls_done <= 1'b0;
      ls_err <= 1'b0;
      ld <= 1'b0;
      f3 <= '0;
      off <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      ls_ready <= ready_nxt;
      mem_req <= req_nxt;
      mem_we <= we_nxt;
      mem_addr <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_be <= be_nxt;
      wb_en <= wb_en_nxt;
      wb_addr <= wb_addr_nxt;
      wb_data <= wb_data_nxt;
      ls_done <= done_nxt;
      ls_err <= err_nxt;
      ld <= ld_nxt;
      f3 <= f3_nxt;
      off <= off_nxt;
      cnt <= cnt_nxt;
    end
  end
endmodule
